// File: rtl/control_unit_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcode/funct
// constants, ALU codes, mux selects and the per-state control word.
package control_unit_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTE,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEXEC,
    S_ADDIWB,
    S_JUMP
`ifdef CONTROL_UNIT_GPIO_EN
    , S_GPIOWB
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_IN    = 6'h3F;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic       ADDR_PC      = 1'b0;
  localparam logic       ADDR_ALUOUT  = 1'b1;
  localparam logic [1:0] RDST_RT      = 2'd0;
  localparam logic [1:0] RDST_RD      = 2'd1;
  localparam logic [1:0] RDST_R31     = 2'd2;
  localparam logic [1:0] WD_ALUOUT    = 2'd0;
  localparam logic [1:0] WD_DATA      = 2'd1;
  localparam logic [1:0] WD_GPIO      = 2'd2;
  localparam logic       SRCA_PC      = 1'b0;
  localparam logic       SRCA_REG     = 1'b1;
  localparam logic [1:0] SRCB_B       = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;
  localparam logic [1:0] PCSRC_ALURES = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef enum logic [1:0] {
    ALUOP_NONE,
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT
  } aluop_t;

  typedef struct packed {
    logic       i_or_d;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    aluop_t     alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
  } ctrl_t;

  // Moore decode: every field not set for a state stays at zero.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.i_or_d    = ADDR_PC;
        c.ir_write  = 1'b1;
        c.alu_src_a = SRCA_PC;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_src    = PCSRC_ALURES;
        c.pc_write  = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_PC;
        c.alu_src_b = SRCB_IMM_SH2;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEXEC: begin
        c.alu_src_a = SRCA_REG;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: c.i_or_d = ADDR_ALUOUT;
      S_MEMWB: begin
        c.reg_dst    = RDST_RT;
        c.mem_to_reg = WD_DATA;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.i_or_d    = ADDR_ALUOUT;
        c.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        c.alu_src_a = SRCA_REG;
        c.alu_src_b = SRCB_B;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.reg_dst    = RDST_RD;
        c.mem_to_reg = WD_ALUOUT;
        c.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = SRCA_REG;
        c.alu_src_b = SRCB_B;
        c.alu_op    = ALUOP_SUB;
        c.pc_src    = PCSRC_ALUOUT;
        c.branch    = 1'b1;
      end
      S_ADDIWB: begin
        c.reg_dst    = RDST_RT;
        c.mem_to_reg = WD_ALUOUT;
        c.reg_write  = 1'b1;
      end
      S_JUMP: begin
        c.pc_src   = PCSRC_JUMP;
        c.pc_write = 1'b1;
      end
`ifdef CONTROL_UNIT_GPIO_EN
      S_GPIOWB: begin
        c.reg_dst    = RDST_RT;
        c.mem_to_reg = WD_GPIO;
        c.reg_write  = 1'b1;
      end
`endif
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/control_unit_alu_decoder.sv
// ALU decoder: maps the state-derived ALUOp and the R-type funct field to an
// ALU_Control code, and flags funct values the datapath does not implement.
module alu_decoder
  import control_unit_pkg::*;
(
  input  aluop_t     i_alu_op,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_control,
  output logic       o_funct_illegal
);

  logic [2:0] w_funct_ctl;

  // The illegal flag depends on funct alone; the caller qualifies it by state.
  always_comb begin
    w_funct_ctl     = ALU_AND;
    o_funct_illegal = 1'b0;
    case (i_funct)
      FUNCT_ADD: w_funct_ctl = ALU_ADD;
      FUNCT_SUB: w_funct_ctl = ALU_SUB;
      FUNCT_AND: w_funct_ctl = ALU_AND;
      FUNCT_OR:  w_funct_ctl = ALU_OR;
      FUNCT_SLT: w_funct_ctl = ALU_SLT;
      default:   o_funct_illegal = 1'b1;
    endcase
  end

  always_comb begin
    o_alu_control = 3'b000;
    case (i_alu_op)
      ALUOP_ADD:   o_alu_control = ALU_ADD;
      ALUOP_SUB:   o_alu_control = ALU_SUB;
      ALUOP_FUNCT: o_alu_control = w_funct_ctl;
      default:     o_alu_control = 3'b000;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multicycle MIPS-style control FSM with Moore outputs decoded from the state
// register. Define CONTROL_UNIT_GPIO_EN to add the IN (0x3F) instruction.
module control_unit
  import control_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PC_En,
  output logic       I_or_D,
  output logic       Mem_Write,
  output logic       IR_Write,
  output logic [1:0] Reg_Dst,
  output logic [1:0] Mem_to_Reg,
  output logic       Reg_Write,
  output logic       ALU_Src_A,
  output logic [1:0] ALU_Src_B,
  output logic [2:0] ALU_Control,
  output logic [1:0] PC_Src,
  output logic       Illegal_Op
);

  state_t r_state;
  state_t w_next_state;
  ctrl_t  w_ctl;
  logic   w_op_illegal;
  logic   w_funct_illegal;
  logic   r_illegal;

  always_comb begin
    w_next_state = S_FETCH;
    w_op_illegal = 1'b0;
    case (r_state)
      S_FETCH: w_next_state = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_RTYPE:     w_next_state = S_EXECUTE;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_ADDI:      w_next_state = S_ADDIEXEC;
          OP_J:         w_next_state = S_JUMP;
`ifdef CONTROL_UNIT_GPIO_EN
          OP_IN:        w_next_state = S_GPIOWB;
`endif
          default:      w_op_illegal = 1'b1;
        endcase
      end
      S_MEMADR:   w_next_state = (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next_state = S_MEMWB;
      S_EXECUTE:  w_next_state = S_ALUWB;
      S_ADDIEXEC: w_next_state = S_ADDIWB;
      default:    w_next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  // Illegal_Op is sticky until reset; unsupported instructions retire as NOPs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_illegal <= 1'b0;
    end else if ((r_state == S_DECODE && w_op_illegal) ||
                 (r_state == S_EXECUTE && w_funct_illegal)) begin
      r_illegal <= 1'b1;
    end
  end

  assign w_ctl = state_ctrl(r_state);

  alu_decoder u_alu_decoder (
    .i_alu_op        (w_ctl.alu_op),
    .i_funct         (Funct),
    .o_alu_control   (ALU_Control),
    .o_funct_illegal (w_funct_illegal)
  );

  // Funct stays stable in the IR, so ALUWB can re-check it to drop the write.
  assign Reg_Write  = w_ctl.reg_write & ~reset &
                      ~(r_state == S_ALUWB && w_funct_illegal);
  assign Mem_Write  = w_ctl.mem_write & ~reset;
  assign PC_En      = w_ctl.pc_write | (w_ctl.branch & Zero);
  assign I_or_D     = w_ctl.i_or_d;
  assign IR_Write   = w_ctl.ir_write;
  assign Reg_Dst    = w_ctl.reg_dst;
  assign Mem_to_Reg = w_ctl.mem_to_reg;
  assign ALU_Src_A  = w_ctl.alu_src_a;
  assign ALU_Src_B  = w_ctl.alu_src_b;
  assign PC_Src     = w_ctl.pc_src;
  assign Illegal_Op = r_illegal;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios then random
// instruction streams against a per-instruction cycle-trace model.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op, Funct;
  logic       Zero;
  logic       PC_En, I_or_D, Mem_Write, IR_Write, Reg_Write, ALU_Src_A, Illegal_Op;
  logic [1:0] Reg_Dst, Mem_to_Reg, ALU_Src_B, PC_Src;
  logic [2:0] ALU_Control;

  control_unit dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .PC_En(PC_En), .I_or_D(I_or_D), .Mem_Write(Mem_Write), .IR_Write(IR_Write),
    .Reg_Dst(Reg_Dst), .Mem_to_Reg(Mem_to_Reg), .Reg_Write(Reg_Write),
    .ALU_Src_A(ALU_Src_A), .ALU_Src_B(ALU_Src_B), .ALU_Control(ALU_Control),
    .PC_Src(PC_Src), .Illegal_Op(Illegal_Op)
  );

  always #5 clk = ~clk;

`ifdef CONTROL_UNIT_GPIO_EN
  localparam bit GPIO_EN = 1'b1;
`else
  localparam bit GPIO_EN = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [16:0] obs;
  assign obs = {PC_En, I_or_D, Mem_Write, IR_Write, Reg_Dst, Mem_to_Reg, Reg_Write,
                ALU_Src_A, ALU_Src_B, ALU_Control, PC_Src};

  function automatic logic [16:0] pk(input logic pcen, input logic iord, input logic mw,
                                     input logic irw, input logic [1:0] rdst,
                                     input logic [1:0] m2r, input logic rw, input logic sa,
                                     input logic [1:0] sb, input logic [2:0] alu,
                                     input logic [1:0] pcs);
    return {pcen, iord, mw, irw, rdst, m2r, rw, sa, sb, alu, pcs};
  endfunction

  // Named cycle shapes straight from the instruction descriptions.
  function automatic logic [16:0] v_fetch();
    return pk(1, 0, 0, 1, 2'd0, 2'd0, 0, 0, 2'd1, 3'b010, 2'd0);
  endfunction
  function automatic logic [16:0] v_decode();
    return pk(0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd3, 3'b010, 2'd0);
  endfunction

  function automatic bit funct_alu(input logic [5:0] f, output logic [2:0] c);
    c = 3'b000;
    case (f)
      6'h20: c = 3'b010;
      6'h22: c = 3'b110;
      6'h24: c = 3'b000;
      6'h25: c = 3'b001;
      6'h2A: c = 3'b111;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  logic [16:0] v_q[$];
  logic        ill_q[$];
  string       nm_q[$];
  bit          ill_m = 1'b0;

  task automatic push(input string nm, input logic [16:0] v);
    v_q.push_back(v);
    ill_q.push_back(ill_m);
    nm_q.push_back(nm);
  endtask

  task automatic build(input logic [5:0] op, input logic [5:0] funct, input logic zero);
    logic [2:0] alu;
    bit ok;
    push("FETCH", v_fetch());
    push("DECODE", v_decode());
    if (op == 6'h23) begin
      push("MEMADR", pk(0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 2'd2, 3'b010, 2'd0));
      push("MEMREAD", pk(0, 1, 0, 0, 2'd0, 2'd0, 0, 0, 2'd0, 3'b000, 2'd0));
      push("MEMWB", pk(0, 0, 0, 0, 2'd0, 2'd1, 1, 0, 2'd0, 3'b000, 2'd0));
    end else if (op == 6'h2B) begin
      push("MEMADR", pk(0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 2'd2, 3'b010, 2'd0));
      push("MEMWRITE", pk(0, 1, 1, 0, 2'd0, 2'd0, 0, 0, 2'd0, 3'b000, 2'd0));
    end else if (op == 6'h00) begin
      ok = funct_alu(funct, alu);
      push("EXECUTE", pk(0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 2'd0, alu, 2'd0));
      if (!ok) ill_m = 1'b1;
      push("ALUWB", pk(0, 0, 0, 0, 2'd1, 2'd0, ok, 0, 2'd0, 3'b000, 2'd0));
    end else if (op == 6'h04) begin
      push("BRANCH", pk(zero, 0, 0, 0, 2'd0, 2'd0, 0, 1, 2'd0, 3'b110, 2'd1));
    end else if (op == 6'h08) begin
      push("ADDIEXEC", pk(0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 2'd2, 3'b010, 2'd0));
      push("ADDIWB", pk(0, 0, 0, 0, 2'd0, 2'd0, 1, 0, 2'd0, 3'b000, 2'd0));
    end else if (op == 6'h02) begin
      push("JUMP", pk(1, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd0, 3'b000, 2'd2));
    end else if (op == 6'h3F && GPIO_EN) begin
      push("GPIOWB", pk(0, 0, 0, 0, 2'd0, 2'd2, 1, 0, 2'd0, 3'b000, 2'd0));
    end else begin
      ill_m = 1'b1;
    end
  endtask

  // Entry and exit: just after a rising edge with the DUT in FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] funct, input logic zero);
    build(op, funct, zero);
    Op = op;
    Funct = funct;
    Zero = zero;
    while (v_q.size() > 0) begin
      logic [16:0] v;
      logic il;
      string nm;
      v = v_q.pop_front();
      il = ill_q.pop_front();
      nm = nm_q.pop_front();
      #1;
      check($sformatf("op%02h/f%02h/%s", op, funct, nm), {15'd0, obs}, {15'd0, v});
      check($sformatf("op%02h/%s Illegal_Op", op, nm), {31'd0, Illegal_Op}, {31'd0, il});
      @(posedge clk);
      #1;
    end
  endtask

  task automatic full_reset();
    reset = 1'b1;
    #1;
    check("reset outputs", {15'd0, obs}, {15'd0, v_fetch()});
    check("reset Illegal_Op", {31'd0, Illegal_Op}, 32'd0);
    check("reset Mem_Write|Reg_Write", {31'd0, Mem_Write | Reg_Write}, 32'd0);
    ill_m = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic [5:0] legal_ops[7];

  initial begin
    legal_ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02, 6'h3F};
    reset = 1'b1;
    Op = '0;
    Funct = '0;
    Zero = 1'b0;
    @(posedge clk);
    #1;
    full_reset();

    run_instr(6'h00, 6'h22, 1'b0);
    run_instr(6'h23, 6'h00, 1'b0);
    run_instr(6'h2B, 6'h00, 1'b1);
    run_instr(6'h04, 6'h00, 1'b1);
    run_instr(6'h04, 6'h00, 1'b0);
    run_instr(6'h02, 6'h00, 1'b0);
    run_instr(6'h08, 6'h00, 1'b0);
    run_instr(6'h3F, 6'h00, 1'b0);
    full_reset();
    run_instr(6'h3E, 6'h00, 1'b0);
    run_instr(6'h08, 6'h00, 1'b1);

    // Reset pulsed in DECODE aborts the instruction at once.
    Op = 6'h00;
    Funct = 6'h20;
    Zero = 1'b0;
    #1;
    check("abort FETCH", {15'd0, obs}, {15'd0, v_fetch()});
    @(posedge clk);
    #1;
    check("abort DECODE", {15'd0, obs}, {15'd0, v_decode()});
    reset = 1'b1;
    #1;
    check("abort reset outputs", {15'd0, obs}, {15'd0, v_fetch()});
    check("abort Illegal_Op", {31'd0, Illegal_Op}, 32'd0);
    ill_m = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    Op = 6'h02;
    #1;
    check("post-reset FETCH", {15'd0, obs}, {15'd0, v_fetch()});
    @(posedge clk);
    #1;
    check("post-reset DECODE", {15'd0, obs}, {15'd0, v_decode()});
    @(posedge clk);
    #1;
    check("post-reset JUMP", {15'd0, obs},
          {15'd0, pk(1, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd0, 3'b000, 2'd2)});
    @(posedge clk);
    #1;

    for (int i = 0; i < 300; i++) begin
      logic [5:0] op, fn;
      int k;
      if (i % 100 == 50) full_reset();
      k = $urandom_range(0, 9);
      if (k < 7) op = legal_ops[k];
      else op = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) fn = 6'($urandom_range(0, 63));
      else begin
        case ($urandom_range(0, 4))
          0: fn = 6'h20;
          1: fn = 6'h22;
          2: fn = 6'h24;
          3: fn = 6'h25;
          default: fn = 6'h2A;
        endcase
      end
      run_instr(op, fn, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameters: none; all encodings come from the shared package.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 Op  input  6  instruction opcode (Instr[31:26]) from the datapath.
REQ-005 Funct  input  6  R-type function field (Instr[5:0]).
REQ-006 Zero  input  1  combinational ALU-result-is-zero flag.
REQ-007 PC_En  output  1  program-counter load enable.
REQ-008 I_or_D  output  1  memory address select: 0 = PC, 1 = ALU_Out.
REQ-009 Mem_Write  output  1  memory write strobe.
REQ-010 IR_Write  output  1  instruction-register load enable.
REQ-011 Reg_Dst  output  2  write-register select: 0 = rt, 1 = rd, 2 = r31.
REQ-012 Mem_to_Reg  output  2  write-data select: 0 = ALU_Out, 1 = Data, 2 = GPIO_i.
REQ-013 Reg_Write  output  1  register-file write enable.
REQ-014 ALU_Src_A  output  1  ALU A select: 0 = PC, 1 = A register.
REQ-015 ALU_Src_B  output  2  ALU B select: 0 = B, 1 = constant 4, 2 = SignImm, 3 = SignImm<<2.
REQ-016 ALU_Control  output  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-017 PC_Src  output  2  next-PC select: 0 = ALU_Result, 1 = ALU_Out, 2 = jump target.
REQ-018 Illegal_Op  output  1  sticky unsupported-opcode/funct flag.

Function
REQ-019 States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP, GPIOWB; the state register is the only sequential element besides Illegal_Op.
REQ-020 All outputs except PC_En shall be Moore (a function of state only); any output not listed for a state is 0.
REQ-021 PC_En = PC_Write | (Branch & Zero), where PC_Write and Branch are internal state-decoded terms.
REQ-022 FETCH: I_or_D=0, IR_Write=1, ALU_Src_A=0, ALU_Src_B=1, ALU_Control=add, PC_Src=0, PC_Write=1; next state DECODE.
REQ-023 DECODE: ALU_Src_A=0, ALU_Src_B=3, ALU_Control=add (precomputes the branch target).
REQ-024 DECODE next state by Op:
  - 0x23/0x2B -> MEMADR
  - 0x00 -> EXECUTE
  - 0x04 -> BRANCH
  - 0x08 -> ADDIEXEC
  - 0x02 -> JUMP
  - otherwise -> FETCH
REQ-025 MEMADR: ALU_Src_A=1, ALU_Src_B=2, add; next MEMREAD for 0x23, MEMWRITE for 0x2B.
REQ-026 MEMREAD: I_or_D=1 -> MEMWB. MEMWB: Reg_Dst=0, Mem_to_Reg=1, Reg_Write=1 -> FETCH.
REQ-027 MEMWRITE: I_or_D=1, Mem_Write=1 -> FETCH.
REQ-028 EXECUTE: ALU_Src_A=1, ALU_Src_B=0, ALU_Control from Funct -> ALUWB.
  - Funct decode: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt.
  - Any other Funct: the ALUWB write is suppressed and Illegal_Op is set.
REQ-029 ALUWB: Reg_Dst=1, Mem_to_Reg=0, Reg_Write=1 -> FETCH.
REQ-030 BRANCH: ALU_Src_A=1, ALU_Src_B=0, sub, PC_Src=1, Branch=1 -> FETCH; Zero is sampled combinationally in this cycle only.
REQ-031 ADDIEXEC: ALU_Src_A=1, ALU_Src_B=2, add -> ADDIWB. ADDIWB: Reg_Dst=0, Mem_to_Reg=0, Reg_Write=1 -> FETCH.
REQ-032 JUMP: PC_Src=2, PC_Write=1 -> FETCH.
REQ-033 Latency in cycles, FETCH inclusive: lw 5; sw, R-type, addi 4; beq, j 3; unsupported opcode 2.
REQ-034 An unsupported opcode in DECODE sets Illegal_Op; the instruction executes as a NOP.

Reset
REQ-035 While reset is high: state = FETCH, Illegal_Op = 0, and Mem_Write = Reg_Write = 0 regardless of state.
REQ-036 Reset asserted mid-instruction aborts it immediately; the first edge after deassertion leaves FETCH.

Configuration
REQ-037 With CONTROL_UNIT_GPIO_EN defined, Op 0x3F (IN) goes DECODE -> GPIOWB.
  - GPIOWB: Reg_Dst=0, Mem_to_Reg=2, Reg_Write=1 -> FETCH; latency 3.
  - Without the macro, Op 0x3F is unsupported (REQ-034) and GPIOWB is not built.

Structure
REQ-038 control_unit_pkg shall hold the state enum, the opcode/funct constants, the ALU_Control codes and the mux-select codes.
REQ-039 Sub-module alu_decoder maps (state-derived ALUOp, Funct) to ALU_Control and the funct-illegal flag.

Verification
REQ-040 Reset, then Op=0x00, Funct=0x22 -> states FETCH, DECODE, EXECUTE (ALU_Control=110), ALUWB (Reg_Write=1, Reg_Dst=1); back in FETCH on cycle 5.
REQ-041 Op=0x23 -> MEMREAD has I_or_D=1; MEMWB has Reg_Write=1, Mem_to_Reg=1; total 5 cycles. Op=0x2B -> Mem_Write=1 exactly 1 cycle.
REQ-042 Op=0x04 with Zero=1 in BRANCH -> PC_En=1, PC_Src=1. Repeat with Zero=0 -> PC_En=0 in BRANCH.
REQ-043 Op=0x02 -> JUMP has PC_En=1, PC_Src=2; total 3 cycles.
REQ-044 Op=0x3E -> DECODE to FETCH, Illegal_Op=1 and held; reset pulsed during the next DECODE -> Illegal_Op=0 and state=FETCH at once.
REQ-045 Op=0x3F -> GPIOWB with Mem_to_Reg=2 when CONTROL_UNIT_GPIO_EN is defined; Illegal_Op=1 and no Reg_Write when it is not.
